// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: word memory for a hashing initiator that also captures an 8-word digest window.
module sha256_mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_we,
  input  logic [15:0]  mem_addr,
  input  logic [31:0]  mem_write_data,
  output logic [31:0]  mem_read_data,
  input  logic         ld_en,
  input  logic [15:0]  ld_addr,
  input  logic [31:0]  ld_data,
  input  logic         arm,
  input  logic [15:0]  out_base,
  input  logic [255:0] exp_digest,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         match,
  output logic [15:0]  wr_count,
  output logic         err_oor,
  output logic         ld_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2;
  logic [31:0]  mem [DEPTH];
  logic [1:0]   state, state_d;
  logic [15:0]  base, base_d, win_off;
  logic [7:0]   mask, mask_d;
  logic [255:0] digest_d;
  logic [2:0]   win_k;
  logic         in_rng, ld_rng, win_hit, match_d;
  assign in_rng  = {1'b0, mem_addr} < 17'(DEPTH);
  assign ld_rng  = {1'b0, ld_addr} < 17'(DEPTH);
  assign win_off = mem_addr - base;
  assign win_k   = win_off[2:0];
  // arm takes priority: a window write in the arm cycle reaches memory only
  assign win_hit = mem_we && in_rng && win_off < 16'd8 && state != IDLE && !arm;
  assign digest_valid = state == DONE;
  always_comb begin
    state_d  = state;
    base_d   = base;
    mask_d   = mask;
    digest_d = digest;
    if (arm) begin
      state_d  = COLLECT;
      base_d   = out_base;
      mask_d   = '0;
      digest_d = '0;
    end else if (win_hit) begin
      digest_d[{3'd7 - win_k, 5'd0} +: 32] = mem_write_data;
      mask_d[win_k] = 1'b1;
      state_d = (state == COLLECT && mask_d == 8'hFF) ? DONE : state;
    end
    match_d = state_d == DONE && digest_d == exp_digest;
  end
  always_ff @(posedge clk) begin
    if (mem_we && in_rng)
      mem[mem_addr[AW-1:0]] <= mem_write_data;
    else if (ld_en && !mem_we && ld_rng)
      mem[ld_addr[AW-1:0]] <= ld_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      state         <= IDLE;
      base          <= '0;
      mask          <= '0;
      digest        <= '0;
      match         <= 1'b0;
      wr_count      <= '0;
      err_oor       <= 1'b0;
      ld_drop       <= 1'b0;
    end else begin
      mem_read_data <= in_rng ? mem[mem_addr[AW-1:0]] : 32'hDEADBEEF;
      state         <= state_d;
      base          <= base_d;
      mask          <= mask_d;
      digest        <= digest_d;
      match         <= match_d;
      if (mem_we && in_rng && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      err_oor <= err_oor | (mem_we && !in_rng) | (ld_en && !mem_we && !ld_rng);
      ld_drop <= ld_drop | (ld_en && mem_we);
    end
  end
endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb_sha256_mem_responder: directed vectors against a behavioural model plus literal spot checks.
module tb_sha256_mem_responder;
  logic         clk = 0;
  logic         reset_n = 0;
  logic         mem_we = 0;
  logic [15:0]  mem_addr = 0;
  logic [31:0]  mem_write_data = 0;
  logic [31:0]  mem_read_data;
  logic         ld_en = 0;
  logic [15:0]  ld_addr = 0;
  logic [31:0]  ld_data = 0;
  logic         arm = 0;
  logic [15:0]  out_base = 0;
  logic [255:0] exp_digest = 0;
  logic [255:0] digest;
  logic         digest_valid, match, err_oor, ld_drop;
  logic [15:0]  wr_count;
  int checks = 0;
  int failures = 0;

  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  sha256_mem_responder #(.DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .arm(arm),
    .out_base(out_base), .exp_digest(exp_digest), .digest(digest),
    .digest_valid(digest_valid), .match(match), .wr_count(wr_count),
    .err_oor(err_oor), .ld_drop(ld_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // behavioural model: memory as a sparse map, capture as 8 words plus a seen-set
  logic [31:0] mm [int];
  logic [31:0] m_rd, m_word [8];
  bit          m_rd_ok, m_oor, m_drop, m_phase, m_valid, m_match, ready;
  bit   [7:0]  m_got;
  int          m_cnt, m_base, off;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rd = 0; m_rd_ok = 1; m_cnt = 0; m_oor = 0; m_drop = 0;
      m_phase = 0; m_got = 0; m_valid = 0; m_match = 0; ready = 1;
      for (int k = 0; k < 8; k++) m_word[k] = 0;
    end else begin
      if (mem_addr < 256) begin
        m_rd_ok = mm.exists(int'(mem_addr));
        m_rd = m_rd_ok ? mm[int'(mem_addr)] : 0;
      end else begin
        m_rd_ok = 1; m_rd = 32'hDEADBEEF;
      end
      if (mem_we) begin
        if (mem_addr < 256) begin
          mm[int'(mem_addr)] = mem_write_data;
          if (m_cnt < 65535) m_cnt++;
        end else m_oor = 1;
      end
      if (ld_en) begin
        if (mem_we) m_drop = 1;
        else if (ld_addr < 256) mm[int'(ld_addr)] = ld_data;
        else m_oor = 1;
      end
      if (arm) begin
        m_base = int'(out_base); m_phase = 1; m_got = 0;
        for (int k = 0; k < 8; k++) m_word[k] = 0;
      end else if (m_phase && mem_we && mem_addr < 256) begin
        off = (int'(mem_addr) - m_base + 65536) % 65536;
        if (off < 8) begin
          m_word[off] = mem_write_data;
          m_got[off] = 1;
        end
      end
      m_valid = m_phase && m_got == 8'hFF;
      m_match = m_valid && {m_word[0], m_word[1], m_word[2], m_word[3],
                            m_word[4], m_word[5], m_word[6], m_word[7]} == exp_digest;
    end
  end

  always @(negedge clk) if (ready) begin
    if (m_rd_ok) chk("rd_data", 256'(mem_read_data), 256'(m_rd));
    chk("digest", digest, {m_word[0], m_word[1], m_word[2], m_word[3],
                           m_word[4], m_word[5], m_word[6], m_word[7]});
    chk("digest_valid", 256'(digest_valid), 256'(m_valid));
    chk("match", 256'(match), 256'(m_match));
    chk("wr_count", 256'(wr_count), 256'(m_cnt));
    chk("err_oor", 256'(err_oor), 256'(m_oor));
    chk("ld_drop", 256'(ld_drop), 256'(m_drop));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1; mem_addr = a; mem_write_data = d;
    tick;
    mem_we = 0;
  endtask

  task automatic ld(input logic [15:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_addr = a;
    tick;
  endtask

  task automatic do_arm(input logic [15:0] b);
    arm = 1; out_base = b;
    tick;
    arm = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", 256'(mem_read_data), 256'h0);
    chk("reset_valid", 256'(digest_valid), 256'h0);
    reset_n = 1;
    tick;
    for (int i = 0; i < 20; i++) ld(16'(i), 32'(i + 1));
    rd(16'd5);
    chk("read_5", 256'(mem_read_data), 256'h6);
    rd(16'd19);
    chk("read_19", 256'(mem_read_data), 256'h14);
    // read-before-write on the same address
    mem_addr = 16'd3; mem_we = 1; mem_write_data = 32'hAAAA5555;
    tick;
    mem_we = 0;
    chk("rbw_old", 256'(mem_read_data), 256'h4);
    tick;
    chk("rbw_new", 256'(mem_read_data), 256'hAAAA5555);
    chk("rbw_count", 256'(wr_count), 256'h1);
    // out-of-range access
    rd(16'h0100);
    chk("oor_read", 256'(mem_read_data), 256'hDEADBEEF);
    wr(16'h0100, 32'h12345678);
    chk("oor_count", 256'(wr_count), 256'h1);
    chk("oor_flag", 256'(err_oor), 256'h1);
    tick; tick;
    chk("oor_sticky", 256'(err_oor), 256'h1);
    // preload colliding with an initiator write
    ld_en = 1; ld_addr = 16'd7; ld_data = 32'h1;
    mem_we = 1; mem_addr = 16'd7; mem_write_data = 32'h2;
    tick;
    ld_en = 0; mem_we = 0;
    tick;
    chk("drop_data", 256'(mem_read_data), 256'h2);
    chk("drop_flag", 256'(ld_drop), 256'h1);
    // SHA-256("abc") capture
    exp_digest = ABC;
    do_arm(16'h0020);
    for (int k = 0; k < 8; k++) begin
      wr(16'h0020 + 16'(k), ABC[255 - 32 * k -: 32]);
      if (k == 6) chk("abc_not_yet", 256'(digest_valid), 256'h0);
    end
    chk("abc_valid", 256'(digest_valid), 256'h1);
    chk("abc_match", 256'(match), 256'h1);
    chk("abc_digest", digest, ABC);
    wr(16'h0023, 32'h0);
    chk("corrupt_match", 256'(match), 256'h0);
    chk("corrupt_valid", 256'(digest_valid), 256'h1);
    wr(16'h0023, ABC[159:128]);
    chk("restore_match", 256'(match), 256'h1);
    // arm colliding with a window write: capture restarts, memory still written
    arm = 1; out_base = 16'h0020; mem_we = 1; mem_addr = 16'h0020; mem_write_data = 32'hCAFEF00D;
    tick;
    arm = 0; mem_we = 0;
    chk("rearm_valid", 256'(digest_valid), 256'h0);
    chk("rearm_digest", digest, 256'h0);
    tick;
    chk("rearm_mem", 256'(mem_read_data), 256'hCAFEF00D);
    // repeated write overwrites without completing
    wr(16'h0020, 32'h11111111);
    wr(16'h0020, ABC[255:224]);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) chk("repeat_not_yet", 256'(digest_valid), 256'h0);
      wr(16'h0020 + 16'(k), ABC[255 - 32 * k -: 32]);
    end
    chk("repeat_match", 256'(match), 256'h1);
    // window straddling the end of memory never completes
    do_arm(16'h00FC);
    for (int k = 0; k < 8; k++) wr(16'h00FC + 16'(k), 32'(k));
    chk("straddle_valid", 256'(digest_valid), 256'h0);
    chk("straddle_digest", digest, {32'h0, 32'h1, 32'h2, 32'h3, 128'h0});
    // reset in the middle of a capture
    do_arm(16'h0040);
    for (int k = 0; k < 4; k++) wr(16'h0040 + 16'(k), 32'hA0 + 32'(k));
    #2 reset_n = 0;
    #1;
    chk("rst_valid", 256'(digest_valid), 256'h0);
    chk("rst_count", 256'(wr_count), 256'h0);
    chk("rst_rd", 256'(mem_read_data), 256'h0);
    chk("rst_digest", digest, 256'h0);
    tick; tick;
    reset_n = 1;
    for (int k = 0; k < 8; k++) wr(16'h0040 + 16'(k), 32'hB0 + 32'(k));
    chk("rst_idle", 256'(digest_valid), 256'h0);
    chk("rst_idle_digest", digest, 256'h0);
    rd(16'd5);
    chk("rst_mem_kept", 256'(mem_read_data), 256'h6);
    ld(16'h0300, 32'h5);
    chk("ld_oor_flag", 256'(err_oor), 256'h1);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
